// File: rtl/traffic_control_pkg.sv
// rtl/traffic_control_pkg.sv - shared state encoding and lamp constants for the intersection controller
package traffic_control_pkg;

  typedef enum logic [2:0] {
    ST_NS_GREEN  = 3'd0,
    ST_NS_YELLOW = 3'd1,
    ST_ALLRED_A  = 3'd2,
    ST_EW_GREEN  = 3'd3,
    ST_EW_YELLOW = 3'd4,
    ST_ALLRED_B  = 3'd5,
    ST_NS_LEFT   = 3'd6,
    ST_EW_LEFT   = 3'd7
  } state_e;

  localparam logic [2:0] LAMP_ALL  = 3'b111;
  localparam logic [2:0] LAMP_OFF  = 3'b000;
  localparam logic [2:0] LAMP_LEFT = 3'b100;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_control_phase_timer.sv
// rtl/traffic_control_phase_timer.sv - loadable down-counter with a zero flag
module phase_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Holds at zero until reloaded, so the owner decides when a phase ends.
  always_ff @(posedge clk) begin
    if (load)
      count <= load_value;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/traffic_control.sv
// rtl/traffic_control.sv - fixed-time two-way signal controller; TRAFFIC_LEFT_LEAD_EN adds leading left-arrow phases
module traffic_control
  import traffic_control_pkg::*;
#(
  parameter int GREEN_CYCLES  = 20,
  parameter int YELLOW_CYCLES = 5,
  parameter int ALLRED_CYCLES = 2,
  parameter int LEFT_CYCLES   = 8
) (
  output logic [2:0] green_ns,
  output logic [2:0] yellow_ns,
  output logic [2:0] red_ns,
  output logic [2:0] green_ew,
  output logic [2:0] yellow_ew,
  output logic [2:0] red_ew,
  input  logic       clk,
  input  logic       rst_a
);

  localparam int MAX_DUR = max_of(max_of(GREEN_CYCLES, YELLOW_CYCLES),
                                  max_of(ALLRED_CYCLES, LEFT_CYCLES));
  localparam int TW = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  state_e          state;
  state_e          next_state;
  logic            tmr_zero;
  logic [TW-1:0]   load_value;

  function automatic logic [TW-1:0] phase_len_m1(input state_e s);
    case (s)
      ST_NS_GREEN, ST_EW_GREEN:   return TW'(GREEN_CYCLES - 1);
      ST_NS_YELLOW, ST_EW_YELLOW: return TW'(YELLOW_CYCLES - 1);
`ifdef TRAFFIC_LEFT_LEAD_EN
      ST_NS_LEFT, ST_EW_LEFT:     return TW'(LEFT_CYCLES - 1);
`endif
      default:                    return TW'(ALLRED_CYCLES - 1);
    endcase
  endfunction

  always_comb begin
    next_state = ST_ALLRED_B;
    case (state)
      ST_NS_GREEN:  next_state = ST_NS_YELLOW;
      ST_NS_YELLOW: next_state = ST_ALLRED_A;
      ST_EW_GREEN:  next_state = ST_EW_YELLOW;
      ST_EW_YELLOW: next_state = ST_ALLRED_B;
`ifdef TRAFFIC_LEFT_LEAD_EN
      ST_ALLRED_A:  next_state = ST_EW_LEFT;
      ST_ALLRED_B:  next_state = ST_NS_LEFT;
      ST_NS_LEFT:   next_state = ST_NS_GREEN;
      ST_EW_LEFT:   next_state = ST_EW_GREEN;
`else
      ST_ALLRED_A:  next_state = ST_EW_GREEN;
      ST_ALLRED_B:  next_state = ST_NS_GREEN;
`endif
      default:      next_state = ST_ALLRED_B;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_a)
      state <= ST_ALLRED_B;
    else if (tmr_zero)
      state <= next_state;
  end

  // The timer reloads with the duration of whichever phase the FSM enters on this edge.
  assign load_value = rst_a ? phase_len_m1(ST_ALLRED_B) : phase_len_m1(next_state);

  phase_timer #(.WIDTH(TW)) u_phase_timer (
    .clk        (clk),
    .load       (rst_a | tmr_zero),
    .load_value (load_value),
    .zero       (tmr_zero)
  );

  always_comb begin
    green_ns  = LAMP_OFF;
    yellow_ns = LAMP_OFF;
    red_ns    = LAMP_ALL;
    green_ew  = LAMP_OFF;
    yellow_ew = LAMP_OFF;
    red_ew    = LAMP_ALL;
    case (state)
      ST_NS_GREEN:  begin green_ns  = LAMP_ALL; red_ns = LAMP_OFF; end
      ST_NS_YELLOW: begin yellow_ns = LAMP_ALL; red_ns = LAMP_OFF; end
      ST_EW_GREEN:  begin green_ew  = LAMP_ALL; red_ew = LAMP_OFF; end
      ST_EW_YELLOW: begin yellow_ew = LAMP_ALL; red_ew = LAMP_OFF; end
`ifdef TRAFFIC_LEFT_LEAD_EN
      ST_NS_LEFT:   begin green_ns  = LAMP_LEFT; red_ns = ~LAMP_LEFT; end
      ST_EW_LEFT:   begin green_ew  = LAMP_LEFT; red_ew = ~LAMP_LEFT; end
`endif
      default:      ;
    endcase
  end

endmodule

// File: tb/tb_traffic_control.sv
// tb/tb_traffic_control.sv - table, sequence and randomized checks of traffic_control against a phase-schedule model
module tb_traffic_control;

`ifdef TRAFFIC_LEFT_LEAD_EN
  localparam bit LEFT_EN = 1'b1;
`else
  localparam bit LEFT_EN = 1'b0;
`endif

  localparam logic [17:0] L_AR  = {3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 3'b111};
  localparam logic [17:0] L_NSG = {3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111};
  localparam logic [17:0] L_NSY = {3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111};
  localparam logic [17:0] L_NSL = {3'b100, 3'b000, 3'b011, 3'b000, 3'b000, 3'b111};
  localparam logic [17:0] L_EWG = {3'b000, 3'b000, 3'b111, 3'b111, 3'b000, 3'b000};
  localparam logic [17:0] L_EWY = {3'b000, 3'b000, 3'b111, 3'b000, 3'b111, 3'b000};
  localparam logic [17:0] L_EWL = {3'b000, 3'b000, 3'b111, 3'b100, 3'b000, 3'b011};

  localparam int PER0 = LEFT_EN ? 70 : 54;

  logic clk = 1'b0;
  logic rst0, rst1;
  logic [2:0] gns0, yns0, rns0, gew0, yew0, rew0;
  logic [2:0] gns1, yns1, rns1, gew1, yew1, rew1;

  always #5 clk = ~clk;

  traffic_control dut0 (
    .green_ns(gns0), .yellow_ns(yns0), .red_ns(rns0),
    .green_ew(gew0), .yellow_ew(yew0), .red_ew(rew0),
    .clk(clk), .rst_a(rst0)
  );

  traffic_control #(.GREEN_CYCLES(1), .YELLOW_CYCLES(1), .ALLRED_CYCLES(1), .LEFT_CYCLES(1)) dut1 (
    .green_ns(gns1), .yellow_ns(yns1), .red_ns(rns1),
    .green_ew(gew1), .yellow_ew(yew1), .red_ew(rew1),
    .clk(clk), .rst_a(rst1)
  );

  wire [17:0] out0 = {gns0, yns0, rns0, gew0, yew0, rew0};
  wire [17:0] out1 = {gns1, yns1, rns1, gew1, yew1, rew1};

  int vectors = 0;
  int miscompares = 0;
  int k0 = 0;
  int k1 = 0;

  // Lamps expected k non-reset edges after a reset edge: the cycle starts in ALLRED_B.
  function automatic logic [17:0] model(input int k, input int g, input int y, input int a, input int l);
    int          dur [8];
    logic [17:0] lamp[8];
    int          per, t;
    int          ll;
    ll = LEFT_EN ? l : 0;
    dur = '{a, ll, g, y, a, ll, g, y};
    lamp = '{L_AR, L_NSL, L_NSG, L_NSY, L_AR, L_EWL, L_EWG, L_EWY};
    per = 0;
    foreach (dur[i]) per += dur[i];
    t = k % per;
    foreach (dur[i]) begin
      if (t < dur[i]) return lamp[i];
      t -= dur[i];
    end
    return 'x;
  endfunction

  function automatic int violations(input logic [17:0] o);
    int v;
    v = 0;
    for (int i = 0; i < 3; i++) begin
      if ($countones({o[15+i], o[12+i], o[9+i]}) != 1) v++;
      if ($countones({o[6+i], o[3+i], o[i]}) != 1) v++;
      if (!o[9+i] && !o[i]) v++;
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input bit r0, input bit r1);
    rst0 = r0;
    rst1 = r1;
    @(posedge clk);
    #1;
    k0 = r0 ? 0 : k0 + 1;
    k1 = r1 ? 0 : k1 + 1;
    check("dut0_lamps", 32'(out0), 32'(model(k0, 20, 5, 2, 8)));
    check("dut1_lamps", 32'(out1), 32'(model(k1, 1, 1, 1, 1)));
    check("dut0_invariants", 32'(violations(out0)), 32'd0);
    check("dut1_invariants", 32'(violations(out1)), 32'd0);
  endtask

  // Runs dut0 free and reports when full NS green first starts, how long it lasts, and the period.
  task automatic measure(output int first, output int len, output int per);
    int starts[$];
    bit prev;
    prev = 1'b0;
    first = -1;
    len = 0;
    per = -1;
    for (int i = 0; i < 200; i++) begin
      tick(1'b0, 1'b0);
      if (gns0 == 3'b111) begin
        if (!prev) starts.push_back(k0);
        if (starts.size() == 1) len++;
      end
      prev = (gns0 == 3'b111);
      if (starts.size() == 2) break;
    end
    if (starts.size() >= 1) first = starts[0];
    if (starts.size() == 2) per = starts[1] - starts[0];
  endtask

  typedef struct {
    bit          rst;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[10];
  int first, len, per;

  initial begin
`ifdef TRAFFIC_LEFT_LEAD_EN
    tbl = '{'{1'b1, L_AR},  '{1'b1, L_AR},  '{1'b0, L_NSL}, '{1'b0, L_NSG}, '{1'b0, L_NSY},
            '{1'b0, L_AR},  '{1'b0, L_EWL}, '{1'b0, L_EWG}, '{1'b0, L_EWY}, '{1'b0, L_AR}};
`else
    tbl = '{'{1'b1, L_AR},  '{1'b1, L_AR},  '{1'b0, L_NSG}, '{1'b0, L_NSY}, '{1'b0, L_AR},
            '{1'b0, L_EWG}, '{1'b0, L_EWY}, '{1'b0, L_AR},  '{1'b0, L_NSG}, '{1'b0, L_NSY}};
`endif
    rst0 = 1'b1;
    rst1 = 1'b1;

    // Both DUTs held in reset for the first two table rows.
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].rst | (i < 2), tbl[i].rst);
      if (i < 2) check("reset_lamps", 32'(out0), 32'(L_AR));
      check("fast_table", 32'(out1), 32'(tbl[i].exp));
    end

    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    measure(first, len, per);
    check("first_green_k", 32'(first), 32'(2 + (LEFT_EN ? 8 : 0)));
    check("green_len", 32'(len), 32'd20);
    check("period", 32'(per), 32'(PER0));

    // Second measure returns on the first cycle of a fresh NS green; reset on its 10th cycle.
    for (int i = 0; i < 9; i++) tick(1'b0, 1'b0);
    check("pre_reset_green", 32'(gns0), 32'h7);
    tick(1'b1, 1'b0);
    check("midphase_reset", 32'(out0), 32'(L_AR));
    measure(first, len, per);
    check("restart_first_green", 32'(first), 32'(2 + (LEFT_EN ? 8 : 0)));
    check("restart_green_len", 32'(len), 32'd20);
    check("restart_period", 32'(per), 32'(PER0));

    for (int i = 0; i < 600; i++)
      tick($urandom_range(0, 60) == 0, $urandom_range(0, 25) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
